// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall controller.
// The controller connects through the slave modport, the pipeline through master.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       d_srca;
    logic [4:0]       d_srcb;
    logic             d_branch;
    logic [4:0]       e_writereg;
    logic             e_regwrite;
    logic             e_memtoreg;
    logic             e_muldiv;
    logic             e_is_div;
    logic [4:0]       m_writereg;
    logic             m_memtoreg;
    logic             i_req;
    logic             i_ack;
    logic             d_req;
    logic             d_ack;

    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushD;
    logic             flushE;
    logic             flushW;
    logic             muldiv_busy;
    logic             muldiv_done;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output d_srca, d_srcb, d_branch, e_writereg, e_regwrite, e_memtoreg,
               e_muldiv, e_is_div, m_writereg, m_memtoreg, i_req, i_ack,
               d_req, d_ack,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               muldiv_busy, muldiv_done, stall_cycles
    );

    modport slave (
        input  d_srca, d_srcb, d_branch, e_writereg, e_regwrite, e_memtoreg,
               e_muldiv, e_is_div, m_writereg, m_memtoreg, i_req, i_ack,
               d_req, d_ack,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               muldiv_busy, muldiv_done, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use, decode-stage branch operands,
// multi-cycle mul/div occupancy and memory waits, plus a saturating stall counter.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 2,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 32
) (
    input  logic         clk,
    input  logic         resetn,
    hazard_ctrl_if.slave hz
);
    localparam int MAX_N = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [CW-1:0]    ld_val;
    logic [CNT_W-1:0] stall_cnt;

    logic dwait, iwait, lwstall, brstall, mdstall;
    logic e_hit, m_hit;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign e_hit = (hz.e_writereg != 5'd0) &&
                   ((hz.e_writereg == hz.d_srca) || (hz.e_writereg == hz.d_srcb));
    assign m_hit = (hz.m_writereg != 5'd0) &&
                   ((hz.m_writereg == hz.d_srca) || (hz.m_writereg == hz.d_srcb));

    assign dwait   = hz.d_req & ~hz.d_ack;
    assign iwait   = hz.i_req & ~hz.i_ack;
    assign lwstall = hz.e_memtoreg & hz.e_regwrite & e_hit;
    assign brstall = hz.d_branch & ((hz.e_regwrite & e_hit) | (hz.m_memtoreg & m_hit));
    assign mdstall = ((state == S_IDLE) & hz.e_muldiv) | (state == S_BUSY);
    assign ld_val  = hz.e_is_div ? DIV_LD : MULT_LD;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // The IDLE start cycle already stalls, so BUSY lasts N-1 cycles and the
    // done pulse lands N+1 cycles after the op entered E; N=1 skips BUSY.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            S_IDLE: begin
                if (hz.e_muldiv && !dwait) begin
                    cnt_n   = ld_val;
                    state_n = (ld_val == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (!dwait) begin
                    cnt_n = cnt - 1'b1;
                    if (cnt <= CW'(1)) begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (dwait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (mdstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
        end else if (lwstall || brstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (iwait) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
        end
        if (iwait) begin
            stall_f = 1'b1;
        end

        hz.stallF       = resetn & stall_f;
        hz.stallD       = resetn & stall_d;
        hz.stallE       = resetn & stall_e;
        hz.stallM       = resetn & stall_m;
        hz.flushD       = resetn & flush_d;
        hz.flushE       = resetn & flush_e;
        hz.flushW       = resetn & flush_w;
        hz.muldiv_busy  = resetn & (state == S_BUSY);
        hz.muldiv_done  = resetn & (state == S_DONE);
        hz.stall_cycles = resetn ? stall_cnt : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (stall_f && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic,
// each cycle compared against a behavioural model of the stall rules.
module tb_hazard_ctrl;
    localparam int CW     = 4;
    localparam int N_DIV  = 32;
    localparam int N_MULT = 2;
    localparam int SAT    = (1 << CW) - 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    hazard_ctrl_if #(.CNT_W(CW)) hz ();

    hazard_ctrl #(
        .MULT_CYCLES(N_MULT),
        .DIV_CYCLES (N_DIV),
        .CNT_W      (CW)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .hz    (hz.slave)
    );

    always #5 clk = ~clk;

    // Model: an op is "in flight" with progress p of n; progress advances on
    // every cycle without a data wait.
    bit m_act = 0;
    int m_p = 0;
    int m_n = 0;
    int m_cnt = 0;
    bit exp_done = 0;

    logic obs_stallE, obs_busy, obs_done;
    logic [31:0] obs_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit hit(input logic [4:0] r);
        return (r != 5'd0) && ((r == hz.d_srca) || (r == hz.d_srcb));
    endfunction

    task automatic step(input string tag);
        bit dw, iw, lw, br, mds, bsy, dn;
        bit sf, sd, se, sm, fd, fe, fw;
        int ecnt;
        #1;
        dw  = hz.d_req && !hz.d_ack;
        iw  = hz.i_req && !hz.i_ack;
        lw  = hz.e_memtoreg && hz.e_regwrite && hit(hz.e_writereg);
        br  = hz.d_branch && ((hz.e_regwrite && hit(hz.e_writereg)) ||
                              (hz.m_memtoreg && hit(hz.m_writereg)));
        bsy = m_act && (m_p < m_n);
        dn  = m_act && (m_p == m_n);
        mds = m_act ? bsy : hz.e_muldiv;
        {sf, sd, se, sm, fd, fe, fw} = '0;
        if (dw)             {sf, sd, se, sm, fw} = '1;
        else if (mds)       {sf, sd, se} = '1;
        else if (lw || br)  {sf, sd, fe} = '1;
        else if (iw)        {sf, fd} = '1;
        if (iw) sf = 1'b1;
        ecnt = m_cnt;
        if (!resetn) begin
            {sf, sd, se, sm, fd, fe, fw, bsy, dn} = '0;
            ecnt = 0;
        end
        chk({tag, ".stallF"}, 32'(hz.stallF), 32'(sf));
        chk({tag, ".stallD"}, 32'(hz.stallD), 32'(sd));
        chk({tag, ".stallE"}, 32'(hz.stallE), 32'(se));
        chk({tag, ".stallM"}, 32'(hz.stallM), 32'(sm));
        chk({tag, ".flushD"}, 32'(hz.flushD), 32'(fd));
        chk({tag, ".flushE"}, 32'(hz.flushE), 32'(fe));
        chk({tag, ".flushW"}, 32'(hz.flushW), 32'(fw));
        chk({tag, ".busy"},   32'(hz.muldiv_busy), 32'(bsy));
        chk({tag, ".done"},   32'(hz.muldiv_done), 32'(dn));
        chk({tag, ".cnt"},    32'(hz.stall_cycles), 32'(ecnt));
        obs_stallE = hz.stallE;
        obs_busy   = hz.muldiv_busy;
        obs_done   = hz.muldiv_done;
        obs_cnt    = 32'(hz.stall_cycles);
        exp_done   = dn;
        @(posedge clk);
        if (!resetn) begin
            m_act = 0;
            m_cnt = 0;
        end else begin
            if (sf && m_cnt < SAT) m_cnt++;
            if (!m_act) begin
                if (hz.e_muldiv && !dw) begin
                    m_act = 1;
                    m_p   = 1;
                    m_n   = hz.e_is_div ? N_DIV : N_MULT;
                end
            end else if (m_p == m_n) begin
                m_act = 0;
            end else if (!dw) begin
                m_p++;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        hz.d_srca = '0; hz.d_srcb = '0; hz.d_branch = 1'b0;
        hz.e_writereg = '0; hz.e_regwrite = 1'b0; hz.e_memtoreg = 1'b0;
        hz.e_muldiv = 1'b0; hz.e_is_div = 1'b0;
        hz.m_writereg = '0; hz.m_memtoreg = 1'b0;
        hz.i_req = 1'b0; hz.i_ack = 1'b0; hz.d_req = 1'b0; hz.d_ack = 1'b0;
    endtask

    // Issue one mul/div and run it to completion, bounded by max_cyc.
    task automatic run_md(input string tag, input bit div, input int dw_at, input int max_cyc,
                          output int n_st, output int n_bz, output int done_at);
        n_st = 0; n_bz = 0; done_at = 0;
        hz.e_muldiv = 1'b1;
        hz.e_is_div = div;
        for (int i = 1; i <= max_cyc; i++) begin
            hz.d_req = (dw_at != 0) && (i >= dw_at) && (i < dw_at + 3);
            step(tag);
            if (obs_stallE) n_st++;
            if (obs_busy) n_bz++;
            if (obs_done) begin
                done_at = i;
                break;
            end
        end
        hz.e_muldiv = 1'b0;
        hz.d_req = 1'b0;
    endtask

    initial begin
        int n_st, n_bz, done_at, n_done;
        clear_inputs();

        resetn = 1'b0;
        step("reset");
        step("reset");
        chk("reset_cnt", obs_cnt, 32'd0);
        resetn = 1'b1;
        step("idle");

        hz.e_memtoreg = 1'b1; hz.e_regwrite = 1'b1; hz.e_writereg = 5'd8; hz.d_srca = 5'd8;
        step("lw_use");
        hz.e_memtoreg = 1'b0; hz.e_regwrite = 1'b0; hz.e_writereg = 5'd0;
        step("lw_after");
        hz.e_memtoreg = 1'b1; hz.e_regwrite = 1'b1; hz.e_writereg = 5'd0; hz.d_srca = 5'd0;
        step("lw_r0");
        clear_inputs();

        hz.d_branch = 1'b1; hz.d_srcb = 5'd5; hz.e_regwrite = 1'b1; hz.e_writereg = 5'd5;
        step("br_alu");
        hz.e_regwrite = 1'b0; hz.e_writereg = 5'd0; hz.m_writereg = 5'd5; hz.m_memtoreg = 1'b0;
        step("br_m_alu");
        hz.m_memtoreg = 1'b1;
        step("br_m_load");
        clear_inputs();

        run_md("div", 1'b1, 0, 40, n_st, n_bz, done_at);
        chk("div_stallE_cycles", 32'(n_st), 32'd32);
        chk("div_busy_cycles", 32'(n_bz), 32'd31);
        chk("div_done_cycle", 32'(done_at), 32'd33);
        step("div_after");

        run_md("mult", 1'b0, 0, 10, n_st, n_bz, done_at);
        chk("mult_done_cycle", 32'(done_at), 32'd3);

        run_md("div_dwait", 1'b1, 5, 45, n_st, n_bz, done_at);
        chk("div_dwait_done_cycle", 32'(done_at), 32'd36);

        hz.e_muldiv = 1'b1; hz.e_is_div = 1'b1;
        for (int i = 0; i < 23; i++) step("div_pre_rst");
        resetn = 1'b0;
        hz.e_muldiv = 1'b0;
        step("rst_mid");
        chk("rst_mid_stallE", 32'(obs_stallE), 32'd0);
        chk("rst_mid_busy", 32'(obs_busy), 32'd0);
        resetn = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            step("post_rst");
            if (obs_done) n_done++;
        end
        chk("post_rst_no_done", 32'(n_done), 32'd0);
        hz.e_memtoreg = 1'b1; hz.e_regwrite = 1'b1; hz.e_writereg = 5'd9; hz.d_srcb = 5'd9;
        step("lw_post_rst");
        clear_inputs();

        resetn = 1'b0;
        step("rst_sat");
        resetn = 1'b1;
        hz.i_req = 1'b1; hz.i_ack = 1'b0;
        for (int i = 0; i < 20; i++) step("iwait");
        chk("stall_cnt_sat", obs_cnt, 32'(SAT));
        hz.d_req = 1'b1;
        step("iwait_dwait");
        clear_inputs();

        for (int i = 0; i < 3000; i++) begin
            hz.d_srca      = 5'($urandom_range(0, 3));
            hz.d_srcb      = 5'($urandom_range(0, 3));
            hz.d_branch    = ($urandom_range(0, 3) == 0);
            hz.e_writereg  = 5'($urandom_range(0, 3));
            hz.e_regwrite  = $urandom_range(0, 1);
            hz.e_memtoreg  = ($urandom_range(0, 2) == 0);
            hz.m_writereg  = 5'($urandom_range(0, 3));
            hz.m_memtoreg  = $urandom_range(0, 1);
            hz.i_req       = $urandom_range(0, 1);
            hz.i_ack       = $urandom_range(0, 1);
            hz.d_req       = ($urandom_range(0, 3) == 0);
            hz.d_ack       = $urandom_range(0, 1);
            if (!hz.e_muldiv && !m_act && ($urandom_range(0, 29) == 0)) begin
                hz.e_muldiv = 1'b1;
                hz.e_is_div = ($urandom_range(0, 3) == 0);
            end
            resetn = ($urandom_range(0, 299) != 0);
            if (!resetn) hz.e_muldiv = 1'b0;
            if (($urandom_range(0, 499) == 0) && resetn) begin
                resetn = 1'b0;
                step("rnd_rst");
                resetn = 1'b1;
            end
            step("rnd");
            if (exp_done) hz.e_muldiv = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
